// File: rtl/gs232c_bhr_ckpt_ctrl.sv
// Branch-history checkpoint controller: a tagged circular queue of history snapshots
// with in-order retire, an architectural history copy and mispredict/flush restore sequencing.
module gs232c_bhr_ckpt_ctrl #(
    parameter int DEPTH = 8,
    parameter int TW    = 3,
    parameter int HW    = 21
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          alloc_valid,
    input  logic [HW-1:0] alloc_hr,
    output logic          alloc_ready,
    output logic [TW-1:0] alloc_tag,
    input  logic          retire_valid,
    input  logic          retire_taken,
    input  logic          flush_valid,
    input  logic [TW-1:0] flush_tag,
    input  logic          flush_taken,
    input  logic          flush_all,
    output logic          restore_valid,
    output logic [HW-1:0] restore_hr,
    output logic [TW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          tag_err
);

    typedef enum logic {
        ST_RUN,
        ST_RECOVER
    } state_t;

    localparam logic [TW:0] PTR_ONE = (TW+1)'(1);

    state_t        state_q, state_d;
    logic [TW:0]   head_q, head_d;
    logic [TW:0]   tail_q, tail_d;
    logic [HW-1:0] arch_hr_q, arch_hr_d;
    logic          restore_valid_q, restore_valid_d;
    logic [HW-1:0] restore_hr_q, restore_hr_d;
    logic          tag_err_q, tag_err_d;

    logic [HW-1:0] entry_mem [DEPTH];

    logic          alloc_ok;
    logic          retire_ok;
    logic          flush_req;
    logic          flush_legal;
    logic [TW-1:0] flush_dist;
    logic [TW:0]   flush_ptr;

    assign count       = tail_q - head_q;
    assign empty       = (head_q == tail_q);
    assign full        = (head_q[TW-1:0] == tail_q[TW-1:0]) && (head_q[TW] != tail_q[TW]);
    assign alloc_ready = (state_q == ST_RUN) && !full && !flush_valid && !flush_all;
    assign alloc_tag   = tail_q[TW-1:0];

    assign alloc_ok  = alloc_valid && alloc_ready;
    assign retire_ok = retire_valid && !empty;
    assign flush_req = flush_valid && !flush_all;

    // Distance from the oldest entry, modulo DEPTH; the tag is in flight when it
    // lies inside the occupied window seen before any same-cycle retire.
    assign flush_dist  = flush_tag - head_q[TW-1:0];
    assign flush_legal = ({1'b0, flush_dist} < count);
    assign flush_ptr   = head_q + {1'b0, flush_dist};

    always_comb begin
        state_d         = state_q;
        head_d          = head_q;
        tail_d          = tail_q;
        arch_hr_d       = arch_hr_q;
        restore_valid_d = 1'b0;
        restore_hr_d    = restore_hr_q;
        tag_err_d       = tag_err_q;

        if (retire_ok) begin
            head_d    = head_q + PTR_ONE;
            arch_hr_d = {arch_hr_q[HW-2:0], retire_taken};
        end
        if (retire_valid && empty) begin
            tag_err_d = 1'b1;
        end

        if (flush_all) begin
            tail_d          = head_d;
            restore_valid_d = 1'b1;
            restore_hr_d    = arch_hr_d;
            state_d         = ST_RECOVER;
        end else if (flush_req) begin
            if (flush_legal) begin
                // The mispredicted branch keeps its slot; everything younger is dropped.
                tail_d          = flush_ptr + PTR_ONE;
                restore_valid_d = 1'b1;
                restore_hr_d    = {entry_mem[flush_tag][HW-2:0], flush_taken};
                state_d         = ST_RECOVER;
            end else begin
                tag_err_d = 1'b1;
                state_d   = ST_RUN;
            end
        end else begin
            state_d = ST_RUN;
            if (alloc_ok) begin
                tail_d = tail_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (alloc_ok) begin
            entry_mem[tail_q[TW-1:0]] <= alloc_hr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_RUN;
            head_q          <= '0;
            tail_q          <= '0;
            arch_hr_q       <= '0;
            restore_valid_q <= 1'b1;
            restore_hr_q    <= '0;
            tag_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            arch_hr_q       <= arch_hr_d;
            restore_valid_q <= restore_valid_d;
            restore_hr_q    <= restore_hr_d;
            tag_err_q       <= tag_err_d;
        end
    end

    assign restore_valid = restore_valid_q;
    assign restore_hr    = restore_hr_q;
    assign tag_err       = tag_err_q;

endmodule

// File: tb/tb_gs232c_bhr_ckpt_ctrl.sv
// Scoreboard bench for gs232c_bhr_ckpt_ctrl: expected tags and restore values are queued
// when stimulus is driven and compared when the DUT accepts an allocation or strobes a restore.
module tb_gs232c_bhr_ckpt_ctrl;

    localparam int DEPTH = 8;
    localparam int TW    = 3;
    localparam int HW    = 21;

    logic          clock;
    logic          reset;
    logic          alloc_valid;
    logic [HW-1:0] alloc_hr;
    logic          alloc_ready;
    logic [TW-1:0] alloc_tag;
    logic          retire_valid;
    logic          retire_taken;
    logic          flush_valid;
    logic [TW-1:0] flush_tag;
    logic          flush_taken;
    logic          flush_all;
    logic          restore_valid;
    logic [HW-1:0] restore_hr;
    logic [TW:0]   count;
    logic          full;
    logic          empty;
    logic          tag_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] tag_q[$];
    logic [31:0] restore_q[$];

    gs232c_bhr_ckpt_ctrl #(.DEPTH(DEPTH), .TW(TW), .HW(HW)) dut (
        .clock        (clock),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_hr     (alloc_hr),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .retire_valid (retire_valid),
        .retire_taken (retire_taken),
        .flush_valid  (flush_valid),
        .flush_tag    (flush_tag),
        .flush_taken  (flush_taken),
        .flush_all    (flush_all),
        .restore_valid(restore_valid),
        .restore_hr   (restore_hr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .tag_err      (tag_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        alloc_valid  = 1'b0;
        alloc_hr     = '0;
        retire_valid = 1'b0;
        retire_taken = 1'b0;
        flush_valid  = 1'b0;
        flush_tag    = '0;
        flush_taken  = 1'b0;
        flush_all    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        clear_inputs();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        restore_q.push_back(32'h0);
        #1;
    endtask

    task automatic do_alloc(input logic [HW-1:0] hr, input int exp_tag);
        alloc_valid = 1'b1;
        alloc_hr    = hr;
        tag_q.push_back(32'(exp_tag));
        tick();
    endtask

    task automatic do_retire(input logic taken);
        retire_valid = 1'b1;
        retire_taken = taken;
        tick();
    endtask

    // Scoreboard side: pop on every accepted allocation and every restore strobe.
    always @(negedge clock) begin
        if (!reset) begin
            if (alloc_valid && alloc_ready) begin
                check("alloc_expected", 32'(tag_q.size() != 0), 32'd1);
                if (tag_q.size() != 0) check("alloc_tag", 32'(alloc_tag), tag_q.pop_front());
            end
            if (restore_valid) begin
                check("restore_expected", 32'(restore_q.size() != 0), 32'd1);
                if (restore_q.size() != 0) check("restore_hr", 32'(restore_hr), restore_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;

        // Reset state
        do_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ready", 32'(alloc_ready), 32'd1);
        check("rst_tag_err", 32'(tag_err), 32'd0);
        tick();

        // Fill to capacity
        for (int i = 0; i < DEPTH; i++) do_alloc(HW'(i), i);
        check("fill_full", 32'(full), 32'd1);
        check("fill_ready", 32'(alloc_ready), 32'd0);
        check("fill_count", 32'(count), 32'd8);
        alloc_valid = 1'b1;
        alloc_hr    = 21'h1F;
        #1;
        check("ninth_ready", 32'(alloc_ready), 32'd0);
        tick();
        check("ninth_count", 32'(count), 32'd8);

        // Retire three, wrap the tail, then flush_all exposes arch_hr
        do_retire(1'b1);
        do_retire(1'b0);
        do_retire(1'b1);
        check("retire_count", 32'(count), 32'd5);
        for (int i = 0; i < 3; i++) do_alloc(HW'(32'h50 + i), i);
        check("wrap_full", 32'(full), 32'd1);
        flush_all = 1'b1;
        restore_q.push_back(32'h5);
        tick();
        check("fa_count", 32'(count), 32'd0);
        check("fa_empty", 32'(empty), 32'd1);
        check("fa_recover_ready", 32'(alloc_ready), 32'd0);
        tick();
        check("fa_run_ready", 32'(alloc_ready), 32'd1);

        // Mispredict flush on tag 2 with tags 0..5 in flight
        do_reset();
        for (int i = 0; i < 6; i++) do_alloc((i == 2) ? 21'h00ABC : HW'(32'h100 + i), i);
        flush_valid = 1'b1;
        flush_tag   = 3'd2;
        flush_taken = 1'b1;
        #1;
        check("flush_cycle_ready", 32'(alloc_ready), 32'd0);
        restore_q.push_back(32'h01579);
        tick();
        check("flush_count", 32'(count), 32'd3);
        check("flush_recover_ready", 32'(alloc_ready), 32'd0);
        tick();
        check("flush_run_ready", 32'(alloc_ready), 32'd1);
        do_alloc(21'h777, 3);

        // flush_all with a same-cycle retire
        do_reset();
        do_alloc(21'h1, 0);
        do_alloc(21'h2, 1);
        do_retire(1'b1);
        do_retire(1'b1);
        do_alloc(21'h3, 2);
        flush_all    = 1'b1;
        retire_valid = 1'b1;
        retire_taken = 1'b1;
        restore_q.push_back(32'h7);
        tick();
        check("far_empty", 32'(empty), 32'd1);
        check("far_count", 32'(count), 32'd0);
        tick();
        check("pre_err", 32'(tag_err), 32'd0);
        do_retire(1'b1);
        check("empty_retire_err", 32'(tag_err), 32'd1);
        check("empty_retire_count", 32'(count), 32'd0);

        // Illegal flush outside the window: head=4, count=2
        do_reset();
        for (int i = 0; i < 6; i++) do_alloc(HW'(32'h200 + i), i);
        for (int i = 0; i < 4; i++) do_retire(1'b0);
        flush_valid = 1'b1;
        flush_tag   = 3'd1;
        tick();
        check("ill_err", 32'(tag_err), 32'd1);
        check("ill_no_restore", 32'(restore_valid), 32'd0);
        check("ill_count", 32'(count), 32'd2);
        check("ill_tail", 32'(alloc_tag), 32'd6);
        flush_valid = 1'b1;
        flush_tag   = 3'd6;
        tick();
        check("ill_tail_tag_no_restore", 32'(restore_valid), 32'd0);
        check("ill_tail_tag_count", 32'(count), 32'd2);

        // Flush of the head entry with a same-cycle retire, then reset in RECOVER
        flush_valid  = 1'b1;
        flush_tag    = 3'd4;
        flush_taken  = 1'b1;
        retire_valid = 1'b1;
        retire_taken = 1'b0;
        restore_q.push_back(32'h00409);
        tick();
        check("head_flush_empty", 32'(empty), 32'd1);
        check("head_flush_count", 32'(count), 32'd0);
        @(negedge clock);
        #1;
        do_reset();
        check("rr_restore_valid", 32'(restore_valid), 32'd1);
        check("rr_restore_hr", 32'(restore_hr), 32'd0);
        check("rr_tag_err", 32'(tag_err), 32'd0);
        check("rr_count", 32'(count), 32'd0);
        check("rr_ready", 32'(alloc_ready), 32'd1);
        tick();
        tick();

        check("tag_queue_drained", 32'(tag_q.size()), 32'd0);
        check("restore_queue_drained", 32'(restore_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
